impact_resonator: RTL and testbench
===================================

# impact_resonator

Percussive sound voice driven by the frame orchestrator's impact outputs. A non-zero `trigger_resonator` strikes the voice: a decaying envelope is loaded and the pitch is set by `tension`. On each `update_resonator` sample strobe the block advances a triangle-wave phase accumulator, decays the envelope, and forms one 8-bit sample with a sequential shift-add multiplier. The sample drives a 1-bit audio output for the board's speaker pin.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `update_resonator`  in  1  one-cycle sample strobe.
- `trigger_resonator`  in  2  strike level; 0 means no strike.
- `tension`  in  4  pitch select; sampled only on a strike.
- `audio_out`  out  1  1-bit audio; reset 0.
- `sample_q`  out  8  current sample; reset 0.
- `active`  out  1  high while the envelope is non-zero; reset 0.
- `busy`  out  1  high while the multiplier runs; reset 0.
- `overrun`  out  1  sticky flag: a strobe was dropped; reset 0.

## Operation
- Registers:
  - `phase[11:0]`.
  - `env[7:0]`.
  - `ten_l[3:0]`.
  - Multiplier state: `mcand[7:0]`, `mplier[7:0]`, `acc[15:0]`, `cnt[2:0]`.
  - FSM with states IDLE and MUL.
- Strike: any cycle with `trigger_resonator != 0` does all of the following:
  - `env <= trigger_resonator * 85`, giving 85, 170 or 255.
  - `phase <= 0`.
  - `ten_l <= tension`.
- Increment: `inc = ten_l*16 + 32`, 9 bits, range 32..272. `phase` wraps modulo 4096.
- Triangle: `tri = phase[11] ? ~phase[10:3] : phase[10:3]`.
- Decay: `env_n = env - ((env>>4) | (env!=0))`.
  - Subtracts at least 1, so the envelope reaches exactly 0 and holds there.
- Strobe in IDLE, with no strike on the same cycle:
  - `phase <= phase + inc` and `env <= env_n`.
  - `mcand` is loaded with `tri` computed from the new phase; `mplier` is loaded with `env_n`.
  - `acc <= 0`, `cnt <= 0`, FSM goes to MUL.
- MUL, each cycle:
  - If `mplier[cnt]`, add `mcand << cnt` to `acc`.
  - `cnt` increments.
  - When `cnt == 7`: `sample_q <= acc_next[15:8]`, return to IDLE.
- Strobe while in MUL: the strobe is dropped, `overrun <= 1`, and phase/env are unchanged.
- Strike and strobe on the same cycle: the strike wins.
  - The phase/env advance is skipped.
  - The multiply still starts, with operands `tri(0)=0` and the loaded `env`, so the resulting sample is 0.
- Strike during MUL: `env`, `phase` and `ten_l` load immediately. The in-flight multiply uses its latched operands and finishes normally.
- `active = (env != 0)`, registered.
- `busy = (state == MUL)`.
- Output stage: 8-bit free-running `pwm_cnt` increments every clock; `audio_out <= (pwm_cnt < sample_q)`.

## Timing
- Strobe seen at edge T:
  - `phase` and `env` update at edge T.
  - `busy` is high after edge T through edge T+7.
  - `sample_q` updates at edge T+8.
- The orchestrator strobes every 1024 clocks, so overrun never occurs in the system; it exists as a check for the bench.
- Strike: `env`, `phase` and `ten_l` update at the same edge. `active` rises one cycle later.
- `audio_out` lags `sample_q` by one cycle; the PWM period is 256 clocks.
- `rst` during MUL: the FSM returns to IDLE and all registers and outputs clear. A strobe on the reset cycle is ignored.

## Configuration
- `IMPACT_RESONATOR_SIGMA_DELTA_EN` defined: the PWM output stage is replaced by a first-order sigma-delta modulator.
  - 9-bit `{c, sd_acc} <= sd_acc + sample_q`, evaluated every clock.
  - `audio_out <= c`.
  - `sd_acc` resets to 0.
- Undefined: the PWM comparator described above is used.
- Both variants give a mean duty of `sample_q/256`.

## Test plan
- Strike and first sample: reset, then `trigger=3`, `tension=4`, then a strobe → `env` is 255 at the strike and 240 after the strobe; `phase`=96; `sample_q`=11 exactly 8 cycles after the strobe.
- Envelope decay: strike with `trigger=1` (env 85), then 200 strobes → env sequence starts 85, 80, 75; env reaches 0 and stays 0; `active` falls; `sample_q` settles at 0.
- Collision of events: strike and strobe on the same cycle → phase=0, `sample_q`=0 after 8 cycles, `overrun`=0.
- Overrun: a strobe 3 cycles after a previous strobe → `overrun`=1 and stays 1; phase advances once only; the first multiply's `sample_q` is unaffected.
- Wrap: `tension=15` (inc=272) over 16 strobes → phase = 4352 mod 4096 = 256, with no glitch in `tri`.
- Output stage: force `sample_q`=64 → `audio_out` averages 64 high cycles per 256 clocks, checked in both macro builds; `rst` mid-MUL clears everything on the next edge.

Source files
------------

// File: rtl/impact_resonator.sv
// Percussive voice: strike loads a decaying envelope, each sample strobe steps a triangle
// oscillator and forms env*tri with a shift-add multiplier. Build option: IMPACT_RESONATOR_SIGMA_DELTA_EN.
module impact_resonator (
    input  logic       clk,
    input  logic       rst,
    input  logic       update_resonator,
    input  logic [1:0] trigger_resonator,
    input  logic [3:0] tension,
    output logic       audio_out,
    output logic [7:0] sample_q,
    output logic       active,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {IDLE, MUL} state_t;

    state_t      state_q, state_d;
    logic [11:0] phase_q, phase_d;
    logic [7:0]  env_q, env_d;
    logic [3:0]  ten_l_q, ten_l_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sample_d;
    logic        active_q, active_d;
    logic        overrun_q, overrun_d;
    logic        audio_q, audio_d;

    logic        strike;
    logic [7:0]  env_strike;
    logic [8:0]  inc;
    logic [11:0] phase_adv;
    logic [7:0]  env_n;
    logic [15:0] acc_next;

    // Triangle folds the upper half of the phase back down so the waveform never jumps.
    function automatic logic [7:0] tri_of(input logic [11:0] ph);
        return ph[11] ? ~ph[10:3] : ph[10:3];
    endfunction

    // Exponential-ish decay; the OR with 1 guarantees the envelope lands exactly on zero.
    function automatic logic [7:0] decay(input logic [7:0] e);
        return e - ((e >> 4) | {7'd0, (e != 8'd0)});
    endfunction

    assign strike     = (trigger_resonator != 2'd0);
    assign env_strike = {6'd0, trigger_resonator} * 8'd85;
    assign inc        = {1'b0, ten_l_q, 4'd0} + 9'd32;
    assign phase_adv  = phase_q + {3'd0, inc};
    assign env_n      = decay(env_q);
    assign acc_next   = acc_q + (mplier_q[cnt_q] ? ({8'd0, mcand_q} << cnt_q) : 16'd0);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        env_d     = env_q;
        ten_l_d   = ten_l_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        overrun_d = overrun_q;
        active_d  = (env_q != 8'd0);

        case (state_q)
            IDLE: begin
                if (update_resonator) begin
                    if (strike) begin
                        // Strike wins: multiply a zero triangle against the freshly loaded envelope.
                        mcand_d  = 8'd0;
                        mplier_d = env_strike;
                    end else begin
                        phase_d  = phase_adv;
                        env_d    = env_n;
                        mcand_d  = tri_of(phase_adv);
                        mplier_d = env_n;
                    end
                    acc_d   = 16'd0;
                    cnt_d   = 3'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    sample_d = acc_next[15:8];
                    state_d  = IDLE;
                end
                if (update_resonator) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A strike always reloads the voice, even while a multiply is in flight.
        if (strike) begin
            env_d   = env_strike;
            phase_d = 12'd0;
            ten_l_d = tension;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= 12'd0;
            env_q     <= 8'd0;
            ten_l_q   <= 4'd0;
            mcand_q   <= 8'd0;
            mplier_q  <= 8'd0;
            acc_q     <= 16'd0;
            cnt_q     <= 3'd0;
            sample_q  <= 8'd0;
            active_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            env_q     <= env_d;
            ten_l_q   <= ten_l_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            active_q  <= active_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef IMPACT_RESONATOR_SIGMA_DELTA_EN
    logic [7:0] sd_acc_q, sd_acc_d;

    // First-order sigma-delta: the carry out of the accumulator is the output bit.
    always_comb begin
        {audio_d, sd_acc_d} = {1'b0, sd_acc_q} + {1'b0, sample_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sd_acc_q <= 8'd0;
            audio_q  <= 1'b0;
        end else begin
            sd_acc_q <= sd_acc_d;
            audio_q  <= audio_d;
        end
    end
`else
    logic [7:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        audio_d   = (pwm_cnt_q < sample_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= 8'd0;
            audio_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            audio_q   <= audio_d;
        end
    end
`endif

    assign audio_out = audio_q;
    assign active    = active_q;
    assign busy      = (state_q == MUL);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_impact_resonator.sv
// Directed plus randomized bench for impact_resonator with an arithmetic reference of the voice.
module tb_impact_resonator;

    logic       clk = 1'b0;
    logic       rst;
    logic       update_resonator;
    logic [1:0] trigger_resonator;
    logic [3:0] tension;
    logic       audio_out;
    logic [7:0] sample_q;
    logic       active;
    logic       busy;
    logic       overrun;

    impact_resonator dut (
        .clk              (clk),
        .rst              (rst),
        .update_resonator (update_resonator),
        .trigger_resonator(trigger_resonator),
        .tension          (tension),
        .audio_out        (audio_out),
        .sample_q         (sample_q),
        .active           (active),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_phase, m_env, m_ten, m_sample;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int tri_f(input int ph);
        int t;
        ph = ph % 4096;
        t  = (ph / 8) % 256;
        return (ph >= 2048) ? 255 - t : t;
    endfunction

    function automatic int decay_f(input int e);
        if (e == 0) return 0;
        return e - ((e / 16) | 1);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_env = 0; m_ten = 0; m_sample = 0;
    endtask

    // Advance the model by one plain strobe; returns the expected sample.
    function automatic int model_advance();
        m_phase = (m_phase + m_ten * 16 + 32) % 4096;
        m_env   = decay_f(m_env);
        return (tri_f(m_phase) * m_env) / 256;
    endfunction

    task automatic strike(input int trig, input int ten);
        trigger_resonator = trig[1:0];
        tension           = ten[3:0];
        step();
        trigger_resonator = 2'd0;
        m_env = trig * 85; m_phase = 0; m_ten = ten;
        chk("strike_env", dut.env_q, m_env);
        chk("strike_phase", dut.phase_q, 0);
    endtask

    // Strobe (optionally colliding with a strike) and check the full multiply timeline.
    task automatic do_strobe(input int trig, input int ten);
        int exp_s;
        update_resonator  = 1'b1;
        trigger_resonator = trig[1:0];
        tension           = ten[3:0];
        step();
        update_resonator  = 1'b0;
        trigger_resonator = 2'd0;
        if (trig != 0) begin
            m_env = trig * 85; m_phase = 0; m_ten = ten;
            exp_s = 0;
        end else begin
            exp_s = model_advance();
        end
        chk("strobe_phase", dut.phase_q, m_phase);
        chk("strobe_env", dut.env_q, m_env);
        chk("busy_start", busy, 1);
        repeat (7) step();
        chk("busy_hold", busy, 1);
        chk("sample_hold", sample_q, m_sample);
        step();
        chk("sample", sample_q, exp_s);
        chk("busy_end", busy, 0);
        m_sample = exp_s;
    endtask

    // Strobe then strike three cycles later; the in-flight multiply keeps its operands.
    task automatic strobe_then_strike(input int trig, input int ten);
        int exp_s;
        update_resonator = 1'b1;
        step();
        update_resonator = 1'b0;
        exp_s = model_advance();
        repeat (2) step();
        strike(trig, ten);
        repeat (4) step();
        chk("mid_strike_busy", busy, 1);
        step();
        chk("mid_strike_sample", sample_q, exp_s);
        m_sample = exp_s;
    endtask

    task automatic duty_check(input string tag);
        int cnt = 0;
        repeat (2) step();
        repeat (256) begin
            step();
            cnt += int'(audio_out);
        end
        chk(tag, cnt, m_sample);
    endtask

    initial begin
        int exp_s;
        rst = 1'b1; update_resonator = 1'b0; trigger_resonator = 2'd0; tension = 4'd0;
        model_reset();
        repeat (2) step();
        chk("rst_audio", audio_out, 0);
        chk("rst_sample", sample_q, 0);
        chk("rst_active", active, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        step();

        // Strike and first sample
        strike(3, 4);
        chk("active_lag", active, 0);
        step();
        chk("active_rise", active, 1);
        do_strobe(0, 0);
        chk("first_env", dut.env_q, 240);
        chk("first_phase", dut.phase_q, 96);
        chk("first_sample", sample_q, 11);
        duty_check("duty_first");

        // Envelope decay to zero
        strike(1, 2);
        do_strobe(0, 0);
        chk("decay_1", dut.env_q, 80);
        do_strobe(0, 0);
        chk("decay_2", dut.env_q, 75);
        for (int i = 0; i < 198; i++) do_strobe(0, 0);
        step();
        chk("decay_env0", dut.env_q, 0);
        chk("decay_inactive", active, 0);
        chk("decay_sample0", sample_q, 0);

        // Collision of strike and strobe
        strike(2, 9);
        do_strobe(0, 0);
        do_strobe(3, 7);
        chk("collide_phase", dut.phase_q, 0);
        chk("collide_sample", sample_q, 0);
        chk("collide_overrun", overrun, 0);

        // Phase wrap with maximum tension
        strike(3, 15);
        for (int i = 0; i < 16; i++) do_strobe(0, 0);
        chk("wrap_phase", dut.phase_q, 256);

        // Output stage with a larger sample
        strike(3, 15);
        do_strobe(0, 0);
        duty_check("duty_big");

        // Overrun: second strobe three cycles after the first
        update_resonator = 1'b1;
        step();
        update_resonator = 1'b0;
        exp_s = model_advance();
        repeat (2) step();
        update_resonator = 1'b1;
        step();
        update_resonator = 1'b0;
        chk("overrun_set", overrun, 1);
        chk("overrun_phase", dut.phase_q, m_phase);
        chk("overrun_env", dut.env_q, m_env);
        repeat (5) step();
        chk("overrun_sample", sample_q, exp_s);
        m_sample = exp_s;
        repeat (20) step();
        chk("overrun_sticky", overrun, 1);

        // Reset in the middle of a multiply, with a strobe on the reset cycle
        update_resonator = 1'b1;
        step();
        update_resonator = 1'b0;
        repeat (3) step();
        rst = 1'b1; update_resonator = 1'b1;
        step();
        rst = 1'b0; update_resonator = 1'b0;
        model_reset();
        chk("midrst_busy", busy, 0);
        chk("midrst_sample", sample_q, 0);
        chk("midrst_active", active, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_audio", audio_out, 0);
        chk("midrst_phase", dut.phase_q, 0);
        chk("midrst_env", dut.env_q, 0);
        step();
        chk("midrst_idle", busy, 0);

        // Randomized mix of strikes, strobes, collisions and mid-multiply strikes
        for (int i = 0; i < 60; i++) begin
            int r, trig, ten;
            r    = $urandom_range(0, 5);
            trig = $urandom_range(1, 3);
            ten  = $urandom_range(0, 15);
            case (r)
                0:       strike(trig, ten);
                1:       do_strobe(trig, ten);
                2:       strobe_then_strike(trig, ten);
                default: do_strobe(0, 0);
            endcase
            repeat ($urandom_range(0, 3)) step();
        end
        chk("rand_overrun", overrun, 0);
        duty_check("duty_rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
